// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch-side allocation handshake for the ROB allocator.
// Contract: alloc_req is a per-slot request held by dispatch for the cycle it is
// asserted; alloc_gnt answers combinationally in the same cycle and a slot owns
// alloc_idx_* only where its grant bit is set at the clock edge. Grants are
// all-or-nothing: an ungranted request must be re-presented in a later cycle.
`timescale 1ns/1ps
interface rob_alloc_ctrl_if #(
  parameter int IDX_W = 5
);
  logic [1:0]       alloc_req;
  logic [1:0]       alloc_gnt;
  logic [IDX_W-1:0] alloc_idx_0;
  logic [IDX_W-1:0] alloc_idx_1;
  logic             stall_o;

  modport master (
    output alloc_req,
    input  alloc_gnt, alloc_idx_0, alloc_idx_1, stall_o
  );

  modport slave (
    input  alloc_req,
    output alloc_gnt, alloc_idx_0, alloc_idx_1, stall_o
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation/occupancy controller: hands out up to two ROB
// indices per cycle, tracks head/tail/count from retirement, and sequences
// flush and drain. Grant decisions use registered occupancy only, so entries
// retired this cycle are not reusable until the next one.
`timescale 1ns/1ps
module rob_alloc_ctrl #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               drain_req,
  input  logic [1:0]         retire_cnt,
  rob_alloc_ctrl_if.slave    alloc_if,
  output logic [IDX_W-1:0]   head_o,
  output logic [IDX_W-1:0]   tail_o,
  output logic [IDX_W:0]     count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               drain_done_o,
  output logic               err_o,
  output logic [1:0]         state_dbg_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             err_q, err_d;

  logic [1:0]       req_n;
  logic [IDX_W:0]   free_n;
  logic             grant_ok;
  logic [1:0]       gnt;
  logic [1:0]       gnt_n;
  logic             retire_bad;
  logic [1:0]       ret_eff;

  // Grant decision, index assignment and retire legality from registered state
  always_comb begin
    req_n      = {1'b0, alloc_if.alloc_req[0]} + {1'b0, alloc_if.alloc_req[1]};
    free_n     = DEPTH_C - count_q;
    grant_ok   = reset_n && (state_q == ST_RUN) && !flush &&
                 (free_n >= {{(IDX_W-1){1'b0}}, req_n});
    gnt        = grant_ok ? alloc_if.alloc_req : 2'b00;
    gnt_n      = {1'b0, gnt[0]} + {1'b0, gnt[1]};
    retire_bad = (retire_cnt == 2'd3) ||
                 ({{(IDX_W-1){1'b0}}, retire_cnt} > count_q);
    ret_eff    = retire_bad ? 2'd0 : retire_cnt;
  end

  // Pointer, occupancy and sticky-error next state; flush overrides everything
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + IDX_W'(ret_eff);
      tail_d  = tail_q + IDX_W'(gnt_n);
      count_d = count_q + (IDX_W+1)'(gnt_n) - (IDX_W+1)'(ret_eff);
      err_d   = err_q | retire_bad;
    end
  end

  // Drain sequencing: RUN -> DRAIN on request, HELD once empty, back on release
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (drain_req) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (!drain_req)          state_d = ST_RUN;
          else if (count_q == '0)  state_d = ST_HELD;
        end
        ST_HELD:  if (!drain_req) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Indices always follow program order from tail, granted or not
  assign alloc_if.alloc_gnt   = gnt;
  assign alloc_if.alloc_idx_0 = tail_q;
  assign alloc_if.alloc_idx_1 = (alloc_if.alloc_req == 2'b11) ? tail_q + IDX_W'(1) : tail_q;
  assign alloc_if.stall_o     = reset_n && (alloc_if.alloc_req != 2'b00) && (gnt == 2'b00);

  assign head_o       = head_q;
  assign tail_o       = tail_q;
  assign count_o      = count_q;
  assign full_o       = (count_q == DEPTH_C);
  assign empty_o      = (count_q == '0);
  assign drain_done_o = (state_q == ST_HELD);
  assign err_o        = err_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl: each driven cycle pushes its expected
// response; a negedge monitor pops and compares against the DUT outputs.
`timescale 1ns/1ps
module tb_rob_alloc_ctrl;

  localparam int W = 33;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       drain_req;
  logic [1:0] retire_cnt;
  logic [4:0] head_o, tail_o;
  logic [5:0] count_o;
  logic       full_o, empty_o, drain_done_o, err_o;
  logic [1:0] state_dbg_o;

  rob_alloc_ctrl_if #(.IDX_W(5)) bus ();

  rob_alloc_ctrl #(.DEPTH(32), .IDX_W(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .drain_req    (drain_req),
    .retire_cnt   (retire_cnt),
    .alloc_if     (bus.slave),
    .head_o       (head_o),
    .tail_o       (tail_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .drain_done_o (drain_done_o),
    .err_o        (err_o),
    .state_dbg_o  (state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] pack(logic [1:0] g, logic [4:0] i0, logic [4:0] i1,
                                        logic st, logic [4:0] h, logic [4:0] t,
                                        logic [5:0] c, logic fu, logic em,
                                        logic dn, logic er);
    return {g, i0, i1, st, h, t, c, fu, em, dn, er};
  endfunction

  // Monitor: compare the DUT response once per cycle, mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v, act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = pack(bus.alloc_gnt, bus.alloc_idx_0, bus.alloc_idx_1, bus.stall_o,
                   head_o, tail_o, count_o, full_o, empty_o, drain_done_o, err_o);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s actual gnt/i0/i1/stall/head/tail/cnt/full/empty/done/err=%h required=%h",
                 nm, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_out(string nm, logic [1:0] g, logic [4:0] i0, logic [4:0] i1,
                            logic st, logic [4:0] h, logic [4:0] t, logic [5:0] c,
                            logic dn, logic er);
    exp_q.push_back(pack(g, i0, i1, st, h, t, c, (c == 6'd32), (c == 6'd0), dn, er));
    name_q.push_back(nm);
  endtask

  task automatic step(string nm, logic [1:0] req, logic [1:0] ret, logic fl, logic dr,
                      logic [1:0] g, logic [4:0] i0, logic [4:0] i1, logic st,
                      logic [4:0] h, logic [4:0] t, logic [5:0] c, logic dn, logic er);
    @(posedge clk);
    #1;
    bus.alloc_req = req;
    retire_cnt    = ret;
    flush         = fl;
    drain_req     = dr;
    expect_out(nm, g, i0, i1, st, h, t, c, dn, er);
  endtask

  // Asynchronous reset applied mid-cycle with a live request on the bus
  task automatic do_reset(string nm);
    @(posedge clk);
    #1;
    reset_n       = 1'b0;
    bus.alloc_req = 2'b11;
    retire_cnt    = 2'd0;
    flush         = 1'b0;
    drain_req     = 1'b0;
    #1;
    expect_out(nm, 2'b00, 5'd0, 5'd1, 1'b0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset_n       = 1'b1;
    bus.alloc_req = 2'b00;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    drain_req     = 1'b0;
    retire_cnt    = 2'd0;
    bus.alloc_req = 2'b00;

    do_reset("reset");

    // Fill: 16 dual allocations
    for (int k = 0; k < 16; k++)
      step("fill", 2'b11, 2'd0, 1'b0, 1'b0, 2'b11, 5'(2*k), 5'(2*k+1), 1'b0,
           5'd0, 5'(2*k), 6'(2*k), 1'b0, 1'b0);
    step("full_single_req", 2'b01, 2'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 6'd32, 1'b0, 1'b0);

    // Wrap and retire
    step("full_retire2", 2'b00, 2'd2, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 6'd32, 1'b0, 1'b0);
    step("wrap_alloc", 2'b11, 2'd0, 1'b0, 1'b0, 2'b11, 5'd0, 5'd1, 1'b0, 5'd2, 5'd0, 6'd30, 1'b0, 1'b0);
    step("full_retire2_req", 2'b11, 2'd2, 1'b0, 1'b0, 2'b00, 5'd2, 5'd3, 1'b1, 5'd2, 5'd2, 6'd32, 1'b0, 1'b0);
    step("no_bypass_next", 2'b11, 2'd0, 1'b0, 1'b0, 2'b11, 5'd2, 5'd3, 1'b0, 5'd4, 5'd2, 6'd30, 1'b0, 1'b0);

    // All-or-nothing at count 31
    step("retire1", 2'b00, 2'd1, 1'b0, 1'b0, 2'b00, 5'd4, 5'd4, 1'b0, 5'd4, 5'd4, 6'd32, 1'b0, 1'b0);
    step("aon_pair_denied", 2'b11, 2'd0, 1'b0, 1'b0, 2'b00, 5'd4, 5'd5, 1'b1, 5'd5, 5'd4, 6'd31, 1'b0, 1'b0);
    step("aon_slot1_only", 2'b10, 2'd0, 1'b0, 1'b0, 2'b10, 5'd4, 5'd4, 1'b0, 5'd5, 5'd4, 6'd31, 1'b0, 1'b0);

    // Retire down to 10
    for (int k = 0; k < 11; k++)
      step("drain_down", 2'b00, 2'd2, 1'b0, 1'b0, 2'b00, 5'd5, 5'd5, 1'b0,
           5'(5 + 2*k), 5'd5, 6'(32 - 2*k), 1'b0, 1'b0);

    // Simultaneous alloc + retire
    step("simul", 2'b11, 2'd1, 1'b0, 1'b0, 2'b11, 5'd5, 5'd6, 1'b0, 5'd27, 5'd5, 6'd10, 1'b0, 1'b0);
    step("simul_after", 2'b00, 2'd0, 1'b0, 1'b0, 2'b00, 5'd7, 5'd7, 1'b0, 5'd28, 5'd7, 6'd11, 1'b0, 1'b0);

    // Build to 20, then flush
    for (int k = 0; k < 4; k++)
      step("refill", 2'b11, 2'd0, 1'b0, 1'b0, 2'b11, 5'(7 + 2*k), 5'(8 + 2*k), 1'b0,
           5'd28, 5'(7 + 2*k), 6'(11 + 2*k), 1'b0, 1'b0);
    step("refill_one", 2'b01, 2'd0, 1'b0, 1'b0, 2'b01, 5'd15, 5'd15, 1'b0, 5'd28, 5'd15, 6'd19, 1'b0, 1'b0);
    step("flush", 2'b11, 2'd2, 1'b1, 1'b0, 2'b00, 5'd16, 5'd17, 1'b1, 5'd28, 5'd16, 6'd20, 1'b0, 1'b0);
    step("post_flush", 2'b00, 2'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0);

    // Drain from count 3
    step("drain_prep2", 2'b11, 2'd0, 1'b0, 1'b0, 2'b11, 5'd0, 5'd1, 1'b0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0);
    step("drain_prep1", 2'b01, 2'd0, 1'b0, 1'b0, 2'b01, 5'd2, 5'd2, 1'b0, 5'd0, 5'd2, 6'd2, 1'b0, 1'b0);
    step("drain_enter", 2'b00, 2'd0, 1'b0, 1'b1, 2'b00, 5'd3, 5'd3, 1'b0, 5'd0, 5'd3, 6'd3, 1'b0, 1'b0);
    step("drain_r1", 2'b01, 2'd1, 1'b0, 1'b1, 2'b00, 5'd3, 5'd3, 1'b1, 5'd0, 5'd3, 6'd3, 1'b0, 1'b0);
    step("drain_r2", 2'b11, 2'd1, 1'b0, 1'b1, 2'b00, 5'd3, 5'd4, 1'b1, 5'd1, 5'd3, 6'd2, 1'b0, 1'b0);
    step("drain_r3", 2'b00, 2'd1, 1'b0, 1'b1, 2'b00, 5'd3, 5'd3, 1'b0, 5'd2, 5'd3, 6'd1, 1'b0, 1'b0);
    step("drain_empty", 2'b01, 2'd0, 1'b0, 1'b1, 2'b00, 5'd3, 5'd3, 1'b1, 5'd3, 5'd3, 6'd0, 1'b0, 1'b0);
    step("held", 2'b01, 2'd0, 1'b0, 1'b1, 2'b00, 5'd3, 5'd3, 1'b1, 5'd3, 5'd3, 6'd0, 1'b1, 1'b0);
    step("held_release", 2'b01, 2'd0, 1'b0, 1'b0, 2'b00, 5'd3, 5'd3, 1'b1, 5'd3, 5'd3, 6'd0, 1'b1, 1'b0);
    step("run_again", 2'b01, 2'd0, 1'b0, 1'b0, 2'b01, 5'd3, 5'd3, 1'b0, 5'd3, 5'd3, 6'd0, 1'b0, 1'b0);

    // Illegal retire of 3
    step("retire3", 2'b00, 2'd3, 1'b0, 1'b0, 2'b00, 5'd4, 5'd4, 1'b0, 5'd3, 5'd4, 6'd1, 1'b0, 1'b0);
    step("retire3_err", 2'b00, 2'd0, 1'b0, 1'b0, 2'b00, 5'd4, 5'd4, 1'b0, 5'd3, 5'd4, 6'd1, 1'b0, 1'b1);

    // Reset mid-operation, then over-retire
    do_reset("reset_mid");
    step("err_prep", 2'b01, 2'd0, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0);
    step("over_retire", 2'b00, 2'd2, 1'b0, 1'b0, 2'b00, 5'd1, 5'd1, 1'b0, 5'd0, 5'd1, 6'd1, 1'b0, 1'b0);
    step("over_retire_err", 2'b00, 2'd0, 1'b0, 1'b0, 2'b00, 5'd1, 5'd1, 1'b0, 5'd0, 5'd1, 6'd1, 1'b0, 1'b1);
    step("flush_keeps_err", 2'b00, 2'd0, 1'b1, 1'b0, 2'b00, 5'd1, 5'd1, 1'b0, 5'd0, 5'd1, 6'd1, 1'b0, 1'b1);
    step("after_flush_err", 2'b00, 2'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b1);

    // Let the monitor consume the last vector, with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_alloc_ctrl.md
# rob_alloc_ctrl

Allocation and occupancy controller for the 32-entry reorder buffer. It hands out ROB indices to the two dispatch slots each cycle and tracks head, tail and occupancy from the retire count the ROB reports. It stalls dispatch when entries are short, and supports flush and drain sequencing. It sits between the rename/dispatch stage and the ROB, and replaces free-running index counters with a checked, occupancy-aware allocator.

## Interface
- DEPTH, 32, ROB entries (power of two)
- IDX_W, 5, log2(DEPTH)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all ROB contents
- drain_req  in  1  level; request to block allocation until the ROB is empty
- alloc_req  in  2  bit0 = slot 0 wants an entry, bit1 = slot 1 wants an entry
- retire_cnt  in  2  entries retired by the ROB this cycle (0..2)
- alloc_gnt  out  2  per-slot grant, combinational, same cycle as alloc_req
- alloc_idx_0  out  IDX_W  index for slot 0
- alloc_idx_1  out  IDX_W  index for slot 1
- stall_o  out  1  alloc_req nonzero and alloc_gnt == 0
- head_o  out  IDX_W  oldest live entry
- tail_o  out  IDX_W  next entry to allocate
- count_o  out  IDX_W+1  live entries, 0..DEPTH
- full_o / empty_o  out  1  count_o == DEPTH / count_o == 0
- drain_done_o  out  1  high while in state HELD
- err_o  out  1  sticky protocol error

## Operation
- **Request count:** req_n = popcount(alloc_req); free = DEPTH − count_o, taken from registered state.
- **Grant rule (all-or-nothing):** alloc_gnt = alloc_req only when all of the following hold; otherwise alloc_gnt = 0.
  - state == RUN
  - flush == 0
  - free ≥ req_n
  - Requests are never split across cycles.
- **Index assignment, in program order:**
  - If both bits are set: alloc_idx_0 = tail, alloc_idx_1 = tail+1 (mod DEPTH).
  - If only one bit is set, the granted slot receives tail.
  - Both index outputs always drive these values regardless of grant.
- **Retire:** effective retire r = retire_cnt.
  - retire_cnt == 3 is illegal: r = 0, err_o set.
  - retire_cnt > count_o: r = 0, err_o set.
- **Register update each cycle:**
  - head += r
  - tail += granted count
  - count = count + granted − r
  - Pointers wrap modulo DEPTH.
- **No bypass:** entries freed by retire in cycle N become allocatable in cycle N+1.
- **Flush:** next state is head = tail = count = 0 and state = RUN. Retire and allocation are ignored that cycle. err_o is not cleared.
- **Drain FSM:**
  - RUN → DRAIN when drain_req == 1.
  - DRAIN → HELD when count_o == 0; if already empty, it reaches HELD on the next edge.
  - HELD → RUN when drain_req == 0.
  - A drain_req drop during DRAIN returns to RUN.
  - Flush in any state forces RUN.
  - Retire continues normally in DRAIN.
- err_o is cleared only by reset.

## Timing
- Reset values:
  - head, tail, count: 0
  - state: RUN
  - err_o: 0
  - empty_o: 1; full_o, stall_o, drain_done_o: 0
  - alloc_gnt: 0 while reset_n is low
- alloc_gnt, alloc_idx_*, and stall_o are combinational from alloc_req, flush, and registered state. They settle in the request cycle, and dispatch captures them on the same edge.
- head_o, tail_o, count_o, full_o, empty_o, and drain_done_o are registered. They reflect updates one cycle after the request or retire.
- Simultaneous events:
  - alloc and retire in the same cycle: both are applied.
  - full and retire 2: no grant that cycle; two grants are possible the next cycle.
  - flush beats everything.
- Reset assertion mid-operation clears all state immediately. There is no partial completion.

## Test plan
- **Reset then fill:** alloc_req = 2'b11 for 16 cycles with no retire → idx pairs (0,1)…(30,31); count_o = 32, full_o = 1. Then a request of 2'b01 → alloc_gnt = 0, stall_o = 1.
- **Wrap and retire:** from full, retire_cnt = 2 for one cycle, then request 2'b11 → granted with indices (0,1); head_o = 2, count_o = 32.
- **All-or-nothing:** count_o = 31, request 2'b11 → no grant, stall_o = 1. Request 2'b10 → gnt 2'b10, alloc_idx_1 = tail.
- **Simultaneous:** count_o = 10, request 2'b11 and retire 1 → count_o = 11 next cycle, head_o += 1, tail_o += 2.
- **Flush:** count_o = 20 with flush, request 2'b11 and retire 2 → gnt 0; next cycle head = tail = count = 0, empty_o = 1.
- **Drain and errors:**
  - drain_req with count_o = 3, then retire 1 per cycle → HELD is reached after count hits 0, and drain_done_o rises the cycle after that; grants stay 0 throughout. Dropping drain_req → RUN.
  - retire_cnt = 3, or retire 2 with count_o = 1 → err_o = 1 and count unchanged.
